// File: rtl/result_pooler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | result_pooler: ReLU + 2x2 max-pool of a row-major result stream, with   |
// | a small output FIFO.                              Rev 1.0               |
// +------------------------------------------------------------------------+
module result_pooler #(
  parameter int ROW_LEN    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  overflow
);

  localparam int CW = $clog2(ROW_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] c_COL_LAST = CW'(ROW_LEN - 1);
  localparam logic [0:0]    c_EVEN_ROW = 1'b0;
  localparam logic [0:0]    c_ODD_ROW  = 1'b1;

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_line [ROW_LEN/2];
  logic [DATA_WIDTH:0]   r_mem  [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic                  r_overflow;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_relu;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [CW-2:0]         w_half;
  logic [DATA_WIDTH-1:0] w_above;
  logic [DATA_WIDTH-1:0] w_vmax;
  logic                  w_col_end;
  logic                  w_frame_end;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;
  logic [DATA_WIDTH:0]   w_head;

  assign w_accept    = in_valid & ~clear;
  assign w_relu      = in_data[DATA_WIDTH-1] ? '0 : in_data;
  // Both operands are already non-negative, so an unsigned compare is exact.
  assign w_hmax      = (r_pair > w_relu) ? r_pair : w_relu;
  assign w_half      = r_col[CW-1:1];
  assign w_above     = r_line[w_half];
  assign w_vmax      = (w_above > w_hmax) ? w_above : w_hmax;
  assign w_col_end   = (r_col == c_COL_LAST);
  assign w_frame_end = w_col_end && (r_row == c_COL_LAST);
  assign w_push      = w_accept & r_col[0] & (r_state == c_ODD_ROW);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & out_ready;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= c_EVEN_ROW;
      r_pair  <= '0;
    end else if (clear) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= c_EVEN_ROW;
      r_pair  <= '0;
    end else if (w_accept) begin
      if (!r_col[0]) r_pair <= w_relu;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_frame_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      case (r_state)
        c_EVEN_ROW: if (w_col_end) r_state <= c_ODD_ROW;
        c_ODD_ROW:  if (w_col_end) r_state <= c_EVEN_ROW;
        default:    r_state <= c_EVEN_ROW;
      endcase
    end
  end

  // Line buffer is always written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && (r_state == c_EVEN_ROW)) r_line[w_half] <= w_hmax;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_frame_end, w_vmax};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)   r_wptr     <= r_wptr + 1'b1;
      if (w_pop)  r_rptr     <= r_rptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Head is gated so stale memory never leaks out while empty or in reset.
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & w_head[DATA_WIDTH];
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
